issue_queue_multi: RTL and testbench
====================================

# issue_queue_multi

Parametrised, age-ordered issue queue for the ALU pipe, successor to the single-result issue queue. It sits between rename/dispatch and the ALU. Entries hold an ALU command, two operands and a destination physical tag. Operands that are not yet ready are captured from any of several result-broadcast channels. The oldest fully-ready entry is issued each cycle under a valid/ready handshake, and the whole queue can be flushed.

## Interface
Parameters:
- DEPTH, 8, number of entries (≥2)
- XLEN, 32, operand/result data width
- TAG_W, 8, physical register tag width
- NUM_WB, 2, number of result-broadcast (wakeup) channels (≥1)
- CMD_W, 5, ALU command width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries
- in_write_enable  in  1  dispatch request
- out_full  out  1  queue cannot accept (count == DEPTH)
- out_count  out  $clog2(DEPTH+1)  occupied entries
- in_alu_cmd  in  CMD_W  command
- in_op1_valid, in_op2_valid  in  1 each  operand already holds data
- in_op1, in_op2  in  XLEN each  operand data (used when valid)
- in_op1_tag, in_op2_tag  in  TAG_W each  source tag (used when not valid)
- in_phys_rd  in  TAG_W  destination tag
- wb_valid  in  NUM_WB  per-channel broadcast valid
- wb_tag  in  NUM_WB*TAG_W  packed tags, channel 0 in LSBs
- wb_data  in  NUM_WB*XLEN  packed data, channel 0 in LSBs
- issue_valid  out  1  an entry is presented
- issue_ready  in  1  ALU accepts
- issue_alu_cmd  out  CMD_W
- issue_op1, issue_op2  out  XLEN each
- issue_phys_rd  out  TAG_W

## Operation
- Storage is a collapsing queue. Slot 0 is the oldest. Per slot: valid, cmd, op1/op2 data, op1/op2 ready, op1/op2 tag, phys_rd.
- Dispatch: the entry is accepted when in_write_enable && !out_full && !flush. It is written into slot count (or count-1 if an issue removes an older entry that same cycle). A write while full is dropped silently.
- Dispatch bypass: a non-valid incoming operand whose tag matches a wb channel with wb_valid in the same cycle is stored ready, with that channel's data.
- Wakeup: for every valid slot and each non-ready operand, a match on any channel sets ready and latches data. If several channels match the same tag, the lowest channel index wins.
- Select: the lowest-index slot with valid && op1_ready && op2_ready drives issue_*.
- Issue: on issue_valid && issue_ready the selected slot is removed. Younger slots shift down by one and keep their order. Wakeups landing that cycle are applied to the shifted copies.
- Flush: all valid bits and count go to 0 next edge. Flush overrides write, issue and wakeup in that cycle.
- out_count tracks +1 for an accepted write and −1 for an accepted issue. Both together leave it unchanged.

## Timing
- Reset (rst=0, asynchronous) clears all valid bits and count to 0. During reset: out_full=0, out_count=0, issue_valid=0, and issue_alu_cmd, issue_op1, issue_op2 and issue_phys_rd are all 0.
- When issue_valid=0, all issue_* data outputs are 0.
- issue_* and out_full/out_count are combinational from registered state. They have no path from in_* or wb_*.
- An entry dispatched ready at edge t can be issued in cycle t+1.
- An operand woken by a broadcast at edge t makes the entry issuable in cycle t+1.
- issue_valid must be held with stable data while issue_ready=0, unless an older entry becomes ready first. The oldest-ready entry may change, and the bench must not require stability across that.
- out_full is count-based. A write while full is refused even if an issue occurs in the same cycle.
- If rst asserts mid-operation, the queue is empty immediately. On deassertion the first dispatch lands in slot 0.

## Test plan
- Reset, then dispatch cmd=ADD, op1=5, op2=7 (both valid), phys_rd=3, with issue_ready=1: issue_valid=1 the next cycle, op1=5, op2=7, phys_rd=3. out_count returns to 0 after the handshake edge.
- Dispatch A with op2 waiting on tag 9, then B fully ready, with issue_ready=1: B issues first. Broadcast tag 9/data 0x55 on channel 1: A issues one cycle later with op2=0x55.
- Dispatch an entry waiting on tag 4 while wb_valid[0], wb_tag=4 and data=0x11 in the same cycle: the entry issues the next cycle with the operand = 0x11 (bypass).
- Fill DEPTH=8 entries with issue_ready=0: out_full=1, out_count=8. A 9th write is dropped. Raise issue_ready: eight issues come out in dispatch order.
- Fill 4 entries, assert flush together with in_write_enable: next cycle out_count=0 and issue_valid=0, and the flushed-cycle write is not stored.
- Both wb channels broadcast tag 6 with data 0xA (ch0) and 0xB (ch1) to a waiting entry: the issued operand = 0xA.

Source files
------------

// File: rtl/issue_queue_multi.sv
// Age-ordered collapsing issue queue for the ALU pipe with multi-channel wakeup.
// Ports: dispatch in_*, wakeup wb_*, issue_* valid/ready, flush, out_full/out_count.
module issue_queue_multi #(
  parameter int DEPTH  = 8,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 8,
  parameter int NUM_WB = 2,
  parameter int CMD_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_write_enable,
  output logic                        out_full,
  output logic [$clog2(DEPTH+1)-1:0]  out_count,
  input  logic [CMD_W-1:0]            in_alu_cmd,
  input  logic                        in_op1_valid,
  input  logic                        in_op2_valid,
  input  logic [XLEN-1:0]             in_op1,
  input  logic [XLEN-1:0]             in_op2,
  input  logic [TAG_W-1:0]            in_op1_tag,
  input  logic [TAG_W-1:0]            in_op2_tag,
  input  logic [TAG_W-1:0]            in_phys_rd,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]     wb_tag,
  input  logic [NUM_WB*XLEN-1:0]      wb_data,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [CMD_W-1:0]            issue_alu_cmd,
  output logic [XLEN-1:0]             issue_op1,
  output logic [XLEN-1:0]             issue_op2,
  output logic [TAG_W-1:0]            issue_phys_rd
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic             r1;
    logic             r2;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    logic [TAG_W-1:0] rd;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           woke  [DEPTH+1];
  entry_t           nw;
  entry_t           sel_ent;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH:0]   vld_x;
  logic [CNT_W-1:0] cnt_q, cnt_d, wpos;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_ok;
  logic             do_iss, do_wr;

  // Returns {ready, data}; lowest matching channel wins.
  function automatic logic [XLEN:0] wake(
    input logic             rdy,
    input logic [TAG_W-1:0] tag,
    input logic [XLEN-1:0]  dat
  );
    logic [XLEN:0] r;
    r = {rdy, dat};
    for (int c = NUM_WB-1; c >= 0; c--) begin
      if (!rdy && wb_valid[c]
          && wb_tag[c*TAG_W +: TAG_W] == tag)
        r = {1'b1, wb_data[c*XLEN +: XLEN]};
    end
    return r;
  endfunction

  always_comb begin
    sel_ok  = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (vld_q[i] && ent_q[i].r1 && ent_q[i].r2) begin
        sel_ok  = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign sel_ent       = ent_q[sel_idx];
  assign issue_valid   = sel_ok;
  assign issue_alu_cmd = sel_ok ? sel_ent.cmd : '0;
  assign issue_op1     = sel_ok ? sel_ent.op1 : '0;
  assign issue_op2     = sel_ok ? sel_ent.op2 : '0;
  assign issue_phys_rd = sel_ok ? sel_ent.rd  : '0;
  assign out_full      = (cnt_q == CNT_W'(DEPTH));
  assign out_count     = cnt_q;

  always_comb begin
    do_iss = sel_ok && issue_ready;
    do_wr  = in_write_enable && !out_full;
    // Slots stay packed, so the free slot is count, minus one on issue.
    wpos   = cnt_q - CNT_W'(do_iss);

    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      {woke[i].r1, woke[i].op1} =
        wake(ent_q[i].r1, ent_q[i].t1, ent_q[i].op1);
      {woke[i].r2, woke[i].op2} =
        wake(ent_q[i].r2, ent_q[i].t2, ent_q[i].op2);
      vld_x[i] = vld_q[i];
    end
    woke[DEPTH]  = '0;
    vld_x[DEPTH] = 1'b0;

    nw     = '0;
    nw.cmd = in_alu_cmd;
    {nw.r1, nw.op1} = wake(in_op1_valid, in_op1_tag, in_op1);
    {nw.r2, nw.op2} = wake(in_op2_valid, in_op2_tag, in_op2);
    nw.t1  = in_op1_tag;
    nw.t2  = in_op2_tag;
    nw.rd  = in_phys_rd;

    for (int i = 0; i < DEPTH; i++) begin
      if (do_iss && i >= int'(sel_idx)) begin
        ent_d[i] = woke[i+1];
        vld_d[i] = vld_x[i+1];
      end else begin
        ent_d[i] = woke[i];
        vld_d[i] = vld_q[i];
      end
      if (do_wr && CNT_W'(i) == wpos) begin
        ent_d[i] = nw;
        vld_d[i] = 1'b1;
      end
    end

    cnt_d = cnt_q + CNT_W'(do_wr) - CNT_W'(do_iss);

    if (flush) begin
      vld_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_issue_queue_multi.sv
// Bench for issue_queue_multi: vector table plus scoreboard of issues.
// Directed sequences cover ordering, fill, flush, priority and reset.
module tb_issue_queue_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_write_enable = 1'b0;
  logic        out_full;
  logic [3:0]  out_count;
  logic [4:0]  in_alu_cmd;
  logic        in_op1_valid, in_op2_valid;
  logic [31:0] in_op1, in_op2;
  logic [7:0]  in_op1_tag, in_op2_tag, in_phys_rd;
  logic [1:0]  wb_valid;
  logic [15:0] wb_tag;
  logic [63:0] wb_data;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [4:0]  issue_alu_cmd;
  logic [31:0] issue_op1, issue_op2;
  logic [7:0]  issue_phys_rd;

  issue_queue_multi dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_write_enable(in_write_enable),
    .out_full(out_full), .out_count(out_count),
    .in_alu_cmd(in_alu_cmd),
    .in_op1_valid(in_op1_valid), .in_op2_valid(in_op2_valid),
    .in_op1(in_op1), .in_op2(in_op2),
    .in_op1_tag(in_op1_tag), .in_op2_tag(in_op2_tag),
    .in_phys_rd(in_phys_rd),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_alu_cmd(issue_alu_cmd),
    .issue_op1(issue_op1), .issue_op2(issue_op2),
    .issue_phys_rd(issue_phys_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [7:0]  rd;
  } exp_t;

  typedef struct {
    logic [4:0]  cmd;
    logic        v1;
    logic [31:0] o1;
    logic [7:0]  t1;
    logic        v2;
    logic [31:0] o2;
    logic [7:0]  t2;
    logic [7:0]  rd;
    logic [1:0]  wv;
    logic [7:0]  wt0, wt1;
    logic [31:0] wd0, wd1;
    logic [31:0] e1, e2;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[7];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst && issue_valid && issue_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_issue: got rd %0h want none",
                 issue_phys_rd);
      end else begin
        mon_e = sb.pop_front();
        chk("issue_data",
            128'({issue_alu_cmd, issue_op1, issue_op2, issue_phys_rd}),
            128'(mon_e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_write_enable = 1'b0;
    flush           = 1'b0;
    wb_valid        = '0;
    wb_tag          = '0;
    wb_data         = '0;
    in_alu_cmd      = '0;
    in_op1_valid    = 1'b0;
    in_op2_valid    = 1'b0;
    in_op1          = '0;
    in_op2          = '0;
    in_op1_tag      = '0;
    in_op2_tag      = '0;
    in_phys_rd      = '0;
  endtask

  task automatic disp(input logic [4:0] c,
                      input logic v1, input logic [31:0] o1,
                      input logic [7:0] t1,
                      input logic v2, input logic [31:0] o2,
                      input logic [7:0] t2,
                      input logic [7:0] rd);
    in_write_enable = 1'b1;
    in_alu_cmd      = c;
    in_op1_valid    = v1;
    in_op1          = o1;
    in_op1_tag      = t1;
    in_op2_valid    = v2;
    in_op2          = o2;
    in_op2_tag      = t2;
    in_phys_rd      = rd;
  endtask

  task automatic wb(input int ch, input logic [7:0] t,
                    input logic [31:0] d);
    wb_valid[ch]       = 1'b1;
    wb_tag[ch*8 +: 8]   = t;
    wb_data[ch*32 +: 32] = d;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && sb.size() > 0; n++) step();
    chk("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{5'd0, 1'b1, 32'd5, 8'd0, 1'b1, 32'd7, 8'd0, 8'd3,
              2'b00, 8'd0, 8'd0, 32'd0, 32'd0, 32'd5, 32'd7};
    vt[1] = '{5'd1, 1'b0, 32'd0, 8'd4, 1'b1, 32'h22, 8'd0, 8'd10,
              2'b01, 8'd4, 8'd0, 32'h11, 32'd0, 32'h11, 32'h22};
    vt[2] = '{5'd2, 1'b1, 32'h3, 8'd0, 1'b0, 32'd0, 8'd6, 8'd11,
              2'b11, 8'd6, 8'd6, 32'hA, 32'hB, 32'h3, 32'hA};
    vt[3] = '{5'd3, 1'b0, 32'd0, 8'd20, 1'b0, 32'd0, 8'd21, 8'd12,
              2'b11, 8'd21, 8'd20, 32'hBEEF, 32'hDEAD,
              32'hDEAD, 32'hBEEF};
    vt[4] = '{5'd4, 1'b1, 32'h1234, 8'd7, 1'b1, 32'h5678, 8'd7, 8'd13,
              2'b01, 8'd7, 8'd0, 32'h999, 32'd0, 32'h1234, 32'h5678};
    vt[5] = '{5'd5, 1'b0, 32'd0, 8'd5, 1'b1, 32'h9, 8'd0, 8'd14,
              2'b10, 8'd5, 8'd5, 32'h77, 32'h88, 32'h88, 32'h9};
    vt[6] = '{5'd31, 1'b1, 32'hFFFF_FFFF, 8'd0, 1'b1, 32'd0, 8'd0,
              8'd255, 2'b00, 8'd0, 8'd0, 32'd0, 32'd0,
              32'hFFFF_FFFF, 32'd0};

    clr();
    #1 rst = 1'b0;
    #2;
    chk("rst_full",  128'(out_full),      128'(0));
    chk("rst_count", 128'(out_count),     128'(0));
    chk("rst_valid", 128'(issue_valid),   128'(0));
    chk("rst_cmd",   128'(issue_alu_cmd), 128'(0));
    chk("rst_op1",   128'(issue_op1),     128'(0));
    chk("rst_op2",   128'(issue_op2),     128'(0));
    chk("rst_rd",    128'(issue_phys_rd), 128'(0));
    step();
    step();
    rst = 1'b1;

    for (int k = 0; k < 7; k++) begin
      clr();
      disp(vt[k].cmd, vt[k].v1, vt[k].o1, vt[k].t1,
           vt[k].v2, vt[k].o2, vt[k].t2, vt[k].rd);
      wb_valid = vt[k].wv;
      wb_tag   = {vt[k].wt1, vt[k].wt0};
      wb_data  = {vt[k].wd1, vt[k].wd0};
      issue_ready = 1'b1;
      sb.push_back('{vt[k].cmd, vt[k].e1, vt[k].e2, vt[k].rd});
      step();
      clr();
      chk("vec_count", 128'(out_count), 128'(1));
      chk("vec_valid", 128'(issue_valid), 128'(1));
      step();
      chk("vec_drained", 128'(out_count), 128'(0));
    end

    clr();
    issue_ready = 1'b1;
    disp(5'd2, 1'b1, 32'd1, 8'd0, 1'b0, 32'd0, 8'd9, 8'd1);
    step();
    clr();
    chk("ooo_wait", 128'(issue_valid), 128'(0));
    disp(5'd3, 1'b1, 32'd2, 8'd0, 1'b1, 32'd3, 8'd0, 8'd2);
    sb.push_back('{5'd3, 32'd2, 32'd3, 8'd2});
    step();
    clr();
    chk("ooo_sel", 128'(issue_phys_rd), 128'(2));
    chk("ooo_cnt2", 128'(out_count), 128'(2));
    wb(1, 8'd9, 32'h55);
    sb.push_back('{5'd2, 32'd1, 32'h55, 8'd1});
    step();
    clr();
    chk("ooo_wake", 128'(issue_valid), 128'(1));
    chk("ooo_cnt1", 128'(out_count), 128'(1));
    step();
    chk("ooo_cnt0", 128'(out_count), 128'(0));

    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clr();
      disp(5'(i), 1'b1, 32'(100 + i), 8'd0,
           1'b1, 32'(200 + i), 8'd0, 8'(40 + i));
      sb.push_back('{5'(i), 32'(100 + i), 32'(200 + i), 8'(40 + i)});
      step();
    end
    clr();
    chk("fill_full", 128'(out_full), 128'(1));
    chk("fill_cnt", 128'(out_count), 128'(8));
    chk("fill_head", 128'(issue_op1), 128'(100));
    disp(5'd9, 1'b1, 32'd999, 8'd0, 1'b1, 32'd999, 8'd0, 8'd99);
    step();
    clr();
    chk("drop_cnt", 128'(out_count), 128'(8));
    chk("hold_rd", 128'(issue_phys_rd), 128'(40));
    disp(5'd10, 1'b1, 32'd998, 8'd0, 1'b1, 32'd998, 8'd0, 8'd98);
    issue_ready = 1'b1;
    step();
    clr();
    chk("full_iss_cnt", 128'(out_count), 128'(7));
    drain(20);
    chk("fill_end_cnt", 128'(out_count), 128'(0));

    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clr();
      disp(5'd1, 1'b1, 32'(i), 8'd0, 1'b1, 32'd0, 8'd0, 8'(70 + i));
      step();
    end
    clr();
    chk("pre_flush_cnt", 128'(out_count), 128'(4));
    disp(5'd1, 1'b1, 32'd77, 8'd0, 1'b1, 32'd77, 8'd0, 8'd77);
    flush = 1'b1;
    step();
    clr();
    chk("flush_cnt", 128'(out_count), 128'(0));
    chk("flush_valid", 128'(issue_valid), 128'(0));
    chk("flush_op1", 128'(issue_op1), 128'(0));
    issue_ready = 1'b1;
    step();
    step();
    chk("flush_stays", 128'(out_count), 128'(0));

    clr();
    disp(5'd6, 1'b0, 32'd0, 8'd6, 1'b1, 32'd1, 8'd0, 8'd50);
    step();
    clr();
    chk("prio_wait", 128'(issue_valid), 128'(0));
    wb(0, 8'd6, 32'hA);
    wb(1, 8'd6, 32'hB);
    sb.push_back('{5'd6, 32'hA, 32'd1, 8'd50});
    step();
    clr();
    chk("prio_ready", 128'(issue_valid), 128'(1));
    drain(5);

    issue_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clr();
      disp(5'd2, 1'b1, 32'd3, 8'd0, 1'b1, 32'd4, 8'd0, 8'(80 + i));
      step();
    end
    clr();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cnt", 128'(out_count), 128'(0));
    chk("mid_rst_valid", 128'(issue_valid), 128'(0));
    chk("mid_rst_op1", 128'(issue_op1), 128'(0));
    step();
    rst = 1'b1;
    disp(5'd7, 1'b1, 32'hC0DE, 8'd0, 1'b1, 32'hF00D, 8'd0, 8'd60);
    step();
    clr();
    chk("post_rst_cnt", 128'(out_count), 128'(1));
    chk("post_rst_op1", 128'(issue_op1), 128'(32'hC0DE));
    sb.push_back('{5'd7, 32'hC0DE, 32'hF00D, 8'd60});
    issue_ready = 1'b1;
    drain(5);
    chk("final_cnt", 128'(out_count), 128'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
